// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/execute controls, instruction-memory bus and IF/ID outputs.
// The master modport is the fetch stage's view; slave is the surrounding pipeline's view.
interface fetch_stage_if #(
  parameter int PC_W   = 12,
  parameter int INST_W = 14
);
  logic              stall;
  logic              redirect_en;
  logic [PC_W-1:0]   redirect_pc;
  logic              push_en;
  logic [PC_W-1:0]   push_data;
  logic              pop_en;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_data;
  logic              imem_halt;
  logic [INST_W-1:0] ifid_inst;
  logic [PC_W-1:0]   ifid_pc;
  logic [PC_W-1:0]   ifid_pc1;
  logic              ifid_valid;
  logic              halted;
  logic              stack_err;

  modport master (
    input  stall, redirect_en, redirect_pc, push_en, push_data, pop_en,
    input  imem_data, imem_halt,
    output imem_addr, ifid_inst, ifid_pc, ifid_pc1, ifid_valid, halted, stack_err
  );

  modport slave (
    output stall, redirect_en, redirect_pc, push_en, push_data, pop_en,
    output imem_data, imem_halt,
    input  imem_addr, ifid_inst, ifid_pc, ifid_pc1, ifid_valid, halted, stack_err
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end: PC, IF/ID register and call/return stack.
// Define FETCH_STACK_CHECK_EN to trap stack overflow/underflow into stack_err.
module fetch_stage #(
  parameter int PC_W        = 12,
  parameter int INST_W      = 14,
  parameter int STACK_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.master bus
);
  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
`ifdef FETCH_STACK_CHECK_EN
  localparam int PTR_W = SP_W + 1;
`else
  localparam int PTR_W = SP_W;
`endif

  logic [PC_W-1:0]   pc;
  logic [INST_W-1:0] ifidInst;
  logic [PC_W-1:0]   ifidPc;
  logic [PC_W-1:0]   ifidPc1;
  logic              ifidValid;
  logic              halted;
  logic              stackErr;

  logic [PC_W-1:0]   stackMem [STACK_DEPTH];
  logic [PTR_W-1:0]  sp;
  logic [PTR_W-1:0]  spNext;
  logic [SP_W-1:0]   topIdx;
  logic [SP_W-1:0]   wrIdx;
  logic              wrEn;
  logic              errSet;
  logic [PC_W-1:0]   popTarget;

  assign topIdx = SP_W'(sp - PTR_W'(1));

  // Stack pointer / write decode; push+pop together replaces the top entry.
  always_comb begin
    popTarget = stackMem[topIdx];
    spNext    = sp;
    wrEn      = 1'b0;
    wrIdx     = sp[SP_W-1:0];
    errSet    = 1'b0;
`ifdef FETCH_STACK_CHECK_EN
    if (sp == PTR_W'(0)) begin
      popTarget = PC_W'(0);
    end else begin
      popTarget = stackMem[topIdx];
    end
    if (bus.pop_en && bus.push_en) begin
      wrEn = 1'b1;
      if (sp == PTR_W'(0)) begin
        errSet = 1'b1;
        wrIdx  = SP_W'(0);
        spNext = PTR_W'(1);
      end else begin
        wrIdx  = topIdx;
      end
    end else if (bus.push_en) begin
      if (sp == PTR_W'(STACK_DEPTH)) begin
        errSet = 1'b1;
      end else begin
        wrEn   = 1'b1;
        spNext = sp + PTR_W'(1);
      end
    end else if (bus.pop_en) begin
      if (sp == PTR_W'(0)) begin
        errSet = 1'b1;
      end else begin
        spNext = sp - PTR_W'(1);
      end
    end else begin
      spNext = sp;
    end
`else
    if (bus.pop_en && bus.push_en) begin
      wrEn  = 1'b1;
      wrIdx = topIdx;
    end else if (bus.push_en) begin
      wrEn   = 1'b1;
      spNext = sp + PTR_W'(1);
    end else if (bus.pop_en) begin
      spNext = sp - PTR_W'(1);
    end else begin
      spNext = sp;
    end
`endif
  end

  // Return stack state; the error flag is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp       <= PTR_W'(0);
      stackErr <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) begin
        stackMem[i] <= PC_W'(0);
      end
    end else begin
      sp <= spNext;
      if (wrEn) begin
        stackMem[wrIdx] <= bus.push_data;
      end
      if (errSet) begin
        stackErr <= 1'b1;
      end
    end
  end

  // PC and IF/ID update in priority order: pop, redirect, stall, halted, fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= PC_W'(0);
      ifidInst  <= INST_W'(0);
      ifidPc    <= PC_W'(0);
      ifidPc1   <= PC_W'(0);
      ifidValid <= 1'b0;
      halted    <= 1'b0;
    end else if (bus.pop_en) begin
      pc        <= popTarget;
      ifidValid <= 1'b0;
      halted    <= 1'b0;
    end else if (bus.redirect_en) begin
      pc        <= bus.redirect_pc;
      ifidValid <= 1'b0;
      halted    <= 1'b0;
    end else if (bus.stall) begin
      pc        <= pc;
    end else if (halted) begin
      ifidValid <= 1'b0;
    end else begin
      ifidInst  <= bus.imem_data;
      ifidPc    <= pc;
      ifidPc1   <= pc + PC_W'(1);
      ifidValid <= 1'b1;
      if (bus.imem_halt) begin
        halted <= 1'b1;
      end else begin
        pc     <= pc + PC_W'(1);
      end
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.ifid_inst  = ifidInst;
  assign bus.ifid_pc    = ifidPc;
  assign bus.ifid_pc1   = ifidPc1;
  assign bus.ifid_valid = ifidValid;
  assign bus.halted     = halted;
  assign bus.stack_err  = stackErr;
endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then random control traffic,
// checked against a queue-based behavioural model of the fetch rules.
module tb_fetch_stage;
  localparam int PC_W  = 12;
  localparam int INST_W = 14;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [PC_W-1:0]   addr;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   ipc;
    logic [PC_W-1:0]   ipc1;
    logic              valid;
    logic              halted;
    logic              err;
  } exp_t;

  logic clk;
  logic rst;
  fetch_stage_if #(.PC_W(PC_W), .INST_W(INST_W)) bus ();

  fetch_stage #(.PC_W(PC_W), .INST_W(INST_W), .STACK_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic haltMap [4096];
  exp_t expQ [$];
  int   vectors;
  int   miscompares;

  function automatic logic [INST_W-1:0] imemWord(input logic [PC_W-1:0] a);
    logic [INST_W-1:0] t;
    t = {2'b00, a} * 14'd37;
    return t ^ 14'h1A5;
  endfunction

  assign bus.imem_data = imemWord(bus.imem_addr);
  assign bus.imem_halt = haltMap[bus.imem_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model state
  int              mPc;
  logic [INST_W-1:0] mInst;
  int              mIpc, mIpc1;
  bit              mValid, mHalted, mErr;
`ifdef FETCH_STACK_CHECK_EN
  int              mQ [$];
`else
  int              mMem [DEPTH];
  int              mSp;
`endif

  task automatic modelReset();
    mPc = 0; mInst = '0; mIpc = 0; mIpc1 = 0;
    mValid = 0; mHalted = 0; mErr = 0;
`ifdef FETCH_STACK_CHECK_EN
    mQ.delete();
`else
    mSp = 0;
    for (int i = 0; i < DEPTH; i++) mMem[i] = 0;
`endif
  endtask

  task automatic tick(input bit r, input bit st, input bit re, input int rp,
                      input bit pu, input int pd, input bit po);
    int target;
    exp_t e;
    @(negedge clk);
    rst = r;
    bus.stall = st; bus.redirect_en = re; bus.redirect_pc = rp[PC_W-1:0];
    bus.push_en = pu; bus.push_data = pd[PC_W-1:0]; bus.pop_en = po;
    if (r) begin
      modelReset();
    end else begin
`ifdef FETCH_STACK_CHECK_EN
      target = (mQ.size() > 0) ? mQ[$] : 0;
`else
      target = mMem[(mSp + DEPTH - 1) % DEPTH];
`endif
      if (po) begin
        mPc = target; mValid = 0; mHalted = 0;
      end else if (re) begin
        mPc = rp % 4096; mValid = 0; mHalted = 0;
      end else if (st) begin
        // everything holds
      end else if (mHalted) begin
        mValid = 0;
      end else begin
        mInst = imemWord(mPc[PC_W-1:0]);
        mIpc = mPc; mIpc1 = (mPc + 1) % 4096; mValid = 1;
        if (haltMap[mPc]) mHalted = 1;
        else mPc = (mPc + 1) % 4096;
      end
`ifdef FETCH_STACK_CHECK_EN
      if (pu && po) begin
        if (mQ.size() == 0) begin mErr = 1; mQ.push_back(pd); end
        else mQ[mQ.size()-1] = pd;
      end else if (pu) begin
        if (mQ.size() == DEPTH) mErr = 1; else mQ.push_back(pd);
      end else if (po) begin
        if (mQ.size() == 0) mErr = 1; else void'(mQ.pop_back());
      end
`else
      if (pu && po) mMem[(mSp + DEPTH - 1) % DEPTH] = pd;
      else if (pu) begin mMem[mSp] = pd; mSp = (mSp + 1) % DEPTH; end
      else if (po) mSp = (mSp + DEPTH - 1) % DEPTH;
`endif
    end
    e.addr = mPc[PC_W-1:0]; e.inst = mInst; e.ipc = mIpc[PC_W-1:0];
    e.ipc1 = mIpc1[PC_W-1:0]; e.valid = mValid; e.halted = mHalted; e.err = mErr;
    expQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest expected entry after each edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        check("imem_addr",  32'(bus.imem_addr),  32'(e.addr));
        check("ifid_inst",  32'(bus.ifid_inst),  32'(e.inst));
        check("ifid_pc",    32'(bus.ifid_pc),    32'(e.ipc));
        check("ifid_pc1",   32'(bus.ifid_pc1),   32'(e.ipc1));
        check("ifid_valid", 32'(bus.ifid_valid), 32'(e.valid));
        check("halted",     32'(bus.halted),     32'(e.halted));
        check("stack_err",  32'(bus.stack_err),  32'(e.err));
      end
    end
  end

  initial begin
    int guard;
    vectors = 0; miscompares = 0;
    for (int i = 0; i < 4096; i++) haltMap[i] = 1'b0;
    rst = 1'b1;
    bus.stall = 1'b0; bus.redirect_en = 1'b0; bus.redirect_pc = '0;
    bus.push_en = 1'b0; bus.push_data = '0; bus.pop_en = 1'b0;
    modelReset();

    tick(1, 0, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 0, 0);
    idle(6);
    for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, 0, 0, 0);
    idle(2);
    tick(0, 0, 1, 12'h010, 0, 0, 0);
    idle(1);
    tick(0, 0, 1, 12'h2A0, 0, 0, 0);
    idle(3);
    tick(0, 0, 1, 12'h010, 0, 0, 0);
    idle(1);
    tick(0, 1, 1, 12'h2A0, 0, 0, 0);
    idle(3);
    tick(0, 0, 0, 0, 1, 12'h111, 0);
    idle(1);
    tick(0, 0, 0, 0, 1, 12'h222, 0);
    idle(2);
    tick(0, 0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 0, 1, 12'h300 + i, 0);
    tick(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    for (int i = 0; i < 9; i++) tick(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    tick(1, 0, 0, 0, 0, 0, 0);
    haltMap[7] = 1'b1;
    tick(0, 0, 1, 12'h004, 0, 0, 0);
    idle(6);
    tick(0, 0, 1, 12'h040, 0, 0, 0);
    idle(4);
    haltMap[7] = 1'b0;
    tick(0, 0, 1, 12'hFFD, 0, 0, 0);
    idle(5);
    tick(0, 0, 0, 0, 1, 12'h5A5, 1);
    idle(2);

    for (int i = 0; i < 4096; i++) haltMap[i] = ($urandom_range(63) == 0);
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(299) == 0),
           ($urandom_range(99) < 20),
           ($urandom_range(99) < 8),
           int'($urandom_range(4095)),
           ($urandom_range(99) < 8),
           int'($urandom_range(4095)),
           ($urandom_range(99) < 5));
    end
    idle(2);

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (expQ.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the pipelined processor, directly upstream of the execute datapath. It owns the 12-bit program counter and addresses the combinational instruction memory. It latches each fetched 14-bit instruction, with its PC and PC+1, into the IF/ID pipeline register. It also owns the call/return address stack, so PC redirection (branch, jmp, call, ret), stall, flush and halt are all resolved here.

## Interface
- `PC_W`, default 12: program-counter and return-address width.
- `INST_W`, default 14: instruction width.
- `STACK_DEPTH`, default 8: return-stack entries; must be a power of two.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in 1: from the hazard unit; holds the PC and the IF/ID register.
- `redirect_en` in 1: from execute (taken branch, jmp or call); load `redirect_pc`.
- `redirect_pc` in PC_W: redirect target.
- `push_en` in 1: call; push `push_data` onto the return stack.
- `push_data` in PC_W: return address (the call's PC+1).
- `pop_en` in 1: ret; pop the stack and redirect to the popped value.
- `imem_addr` out PC_W: instruction-memory address, equal to the current PC.
- `imem_data` in INST_W: instruction memory read data, combinational.
- `imem_halt` in 1: instruction memory flags `imem_data` as a halt instruction.
- `ifid_inst` out INST_W: registered instruction.
- `ifid_pc` out PC_W: registered PC of `ifid_inst`.
- `ifid_pc1` out PC_W: registered PC+1, modulo 2^PC_W.
- `ifid_valid` out 1: the IF/ID contents are a real, non-flushed instruction.
- `halted` out 1: fetch frozen on a halt instruction.
- `stack_err` out 1: sticky stack overflow/underflow flag.

## Operation
Reset: `pc`=0, `ifid_inst`=0, `ifid_pc`=0, `ifid_pc1`=0, `ifid_valid`=0, `halted`=0, stack pointer `sp`=0, stack contents=0, `stack_err`=0.

Next-state rules, evaluated each cycle in priority order:
1. `rst`: apply the reset values above.
2. `pop_en`: `pc` <= stack top (`mem[sp-1]`); `sp` decrements; `ifid_valid` <= 0 (flush); `halted` <= 0.
3. `redirect_en`: `pc` <= `redirect_pc`; `ifid_valid` <= 0; `halted` <= 0.
4. `stall`: `pc` and all `ifid_*` registers hold.
5. `halted`: `pc` holds; `ifid_valid` <= 0.
6. Normal fetch:
   - `ifid_inst` <= `imem_data`, `ifid_pc` <= `pc`, `ifid_pc1` <= `pc`+1, `ifid_valid` <= 1.
   - If `imem_halt`: `pc` holds and `halted` <= 1. The halt instruction itself enters IF/ID as valid.
   - Otherwise: `pc` <= `pc`+1, wrapping 0xFFF to 0x000.

Stack rules:
- `push_en` is independent of rules 2-6 and fires even during `stall` or `halted`: `mem[sp]` <= `push_data`, `sp` increments.
- `push_en` with `pop_en` in the same cycle: the top entry is replaced by `push_data` and `sp` is unchanged. The redirect target is the old top.
- `redirect_en` with `pop_en`: pop wins and `redirect_pc` is ignored.
- A halt fetched down a wrong path is cancelled by the later redirect or pop, because both clear `halted`.

## Timing
- Fetch latency is 1 cycle: the instruction at PC N appears in `ifid_*` on the edge after `pc`=N.
- A redirect or pop asserted in cycle T gives `pc` = target in T+1 and valid IF/ID of the target in T+2. The one wrong-path slot shows `ifid_valid`=0.
- `stall` held for k cycles holds IF/ID for exactly k cycles, with no instruction lost or duplicated.
- `stall` is ignored in any cycle where a redirect or pop is asserted.
- The pop target is read combinationally from the current `sp`, so back-to-back pops on consecutive cycles return consecutive entries.
- `halted` rises on the edge that latches the halt instruction. `ifid_valid` falls on the following edge.

## Configuration
- `FETCH_STACK_CHECK_EN` defined:
  - Push with `sp`==STACK_DEPTH is dropped, `sp` is unchanged and `stack_err` <= 1.
  - Pop with `sp`==0 redirects to 0x000, `sp` stays 0 and `stack_err` <= 1.
  - `stack_err` clears only on `rst`.
- `FETCH_STACK_CHECK_EN` undefined:
  - `sp` is log2(STACK_DEPTH) bits and wraps silently. Overflow overwrites the oldest entry; underflow returns `mem[STACK_DEPTH-1]`.
  - `stack_err` is tied to 0.

## Test plan
- Reset, then run 4 cycles with no control inputs: `ifid_pc` = 0,1,2,3, `ifid_valid`=1 from cycle 2, and `ifid_pc1`=`ifid_pc`+1.
- `stall` for 3 cycles while `ifid_pc`=5: `ifid_pc` stays 5 and `pc` stays 6 for 3 cycles, then `ifid_pc` = 6, 7.
- `redirect_en` with `redirect_pc`=0x2A0 while `pc`=0x010: one bubble with `ifid_valid`=0, then `ifid_pc`=0x2A0. Repeat with `stall` asserted in the same cycle: identical result.
- Push 0x111 then 0x222, later pop twice on consecutive cycles: `pc` goes 0x222 then 0x111; `sp` returns to 0 and `stack_err`=0.
- With `FETCH_STACK_CHECK_EN` defined: 9 pushes and 1 pop give a target equal to the 8th push and `stack_err`=1. Pop on an empty stack goes to 0x000 with `stack_err`=1. Undefined: the 9th push overwrites entry 0 and `stack_err` stays 0.
- `imem_halt` at PC 7: `ifid_pc`=7 valid, `halted`=1, then `ifid_valid`=0 with `pc` held. A later `redirect_en` to 0x040 clears `halted` and fetch resumes at 0x040.
